imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Host-side programmer for the CPU instruction memory. It is the writing end of the `writeI`/`TPC`/`dataI` programming interface.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to consecutive word addresses, checks an XOR checksum, then releases the core with a `softReset` pulse followed by `power` high.

Parameters:
MAX_WORDS, 256, largest accepted program length in words (1..65535)
BASE_ADDR, 0, byte address of the first written word (multiple of 4)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  begin a load session; sampled only in IDLE, RUN or ERR
byteIn  input  8  stream byte
byteValid  input  1  byteIn is valid this cycle
byteReady  output  1  loader can accept a byte; transfer = byteValid & byteReady
writeI  output  1  instruction-memory write strobe, one cycle per word
TPC  output  32  instruction-memory byte address
dataI  output  32  instruction word to write
softReset  output  1  one-cycle pulse to the core after a successful load
power  output  1  core run enable
busy  output  1  high in HDR0..SRST
done  output  1  high in RUN
error  output  1  high in ERR

Behaviour:
- Reset (async, active-high): state=IDLE.
  - All outputs are 0: byteReady, writeI, TPC, dataI, softReset, power, busy, done, error.
  - Word counter, byte counter, checksum and length register are all 0.
- Frame layout: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N payload bytes (MSB first per word), then CHK.
  - CHK = XOR of all 4*N payload bytes. Length bytes are excluded from CHK.
- States: IDLE, HDR0, HDR1, LOAD, WRITE, CHK, SRST, RUN, ERR.
- IDLE:
  - start=1 -> HDR0.
  - On that transition: checksum:=0, word counter:=0, byte counter:=0, power:=0.
- HDR0: byteReady=1. On transfer, len[15:8]:=byteIn -> HDR1.
- HDR1: byteReady=1. On transfer, len[7:0]:=byteIn.
  - If {len[15:8],byteIn}==0 or >MAX_WORDS -> ERR.
  - Otherwise -> LOAD.
- LOAD:
  - byteReady=1.
  - Each transfer shifts byteIn into the low byte of the word register, XORs byteIn into checksum, and increments the byte counter (mod 4).
  - On the 4th byte -> WRITE.
- WRITE:
  - byteReady=0 for exactly one cycle. writeI=1, dataI=assembled word, TPC=BASE_ADDR + 4*wordcount.
  - Word counter increments.
  - If the new count == N -> CHK, else -> LOAD.
- Output timing:
  - TPC and dataI are registered: valid in the WRITE cycle, held afterwards until the next write or reset.
  - writeI is 0 in every other state.
- CHK: byteReady=1. On transfer, byteIn==checksum -> SRST, else -> ERR.
- SRST: softReset=1 for one cycle, power=0 -> RUN.
- RUN: power=1, done=1. start=1 -> HDR0 with power dropped to 0 in the same cycle as the transition.
- ERR: error=1, power=0. Stays in ERR until start=1 -> HDR0, which clears error.
- Handshake rules:
  - A byte is consumed only when byteValid & byteReady. Idle gaps of any length between bytes are legal.
  - byteValid while byteReady=0 is not consumed and has no effect.
- start while busy=1 is ignored.
- Latency: last payload byte accepted at cycle t -> writeI at t+1. CHK accepted at t -> softReset at t+1 -> power=1, done=1 at t+2.
- Reset mid-session: returns to IDLE immediately. Words already written stay in instruction memory. power stays 0 until a full successful load.
- Address arithmetic is 32-bit unsigned. The maximum address written is BASE_ADDR + 4*(N-1).

Test Plan:
- Frame 00 01 | 20 01 00 05 | CHK=24 -> one writeI with TPC=0, dataI=32'h20010005; softReset pulse; then power=1, done=1.
- Frame with N=3: words 11111111, 22222222, 33333333, CHK=00 -> writes at TPC=0,4,8 one cycle each; byteReady=0 in each WRITE cycle.
- Same 1-word frame with CHK=25 -> ERR, error=1, power=0, no softReset. A following start -> HDR0 with error cleared.
- Length 00 00, and length 01 01 with MAX_WORDS=256 -> ERR right after LEN_LO; zero writeI pulses.
- Random byteValid gaps (0-5 idle cycles) on the N=3 frame -> identical writes and final state. Bytes offered during WRITE are not consumed.
- Assert reset during the 2nd word of an N=3 load -> all outputs 0 within the same cycle (async). A new start reloads correctly from TPC=0.

Source files
------------

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Host-side programmer for the CPU instruction memory. It receives a framed
// byte stream over a valid/ready handshake and assembles big-endian 32-bit
// words. It writes each word to consecutive instruction-memory addresses over
// the writeI/TPC/dataI interface and checks an XOR checksum. After a good
// load it releases the core with a one-cycle softReset pulse, followed by
// power held high.
//
// Frame: LEN_HI, LEN_LO (word count N), 4*N payload bytes (MSB first), CHK.
//        CHK is the XOR of the payload bytes only.
//
// Parameters:
//   MAX_WORDS  largest accepted program length in words (1..65535)
//   BASE_ADDR  byte address of the first written word (multiple of 4)
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous active-high reset, clears all state
//   start      begin a load session (honoured only in IDLE, RUN or ERR)
//   byteIn     stream byte
//   byteValid  byteIn is valid this cycle
//   byteReady  loader accepts a byte; transfer = byteValid & byteReady
//   writeI     instruction-memory write strobe, one cycle per word
//   TPC        instruction-memory byte address (registered, held)
//   dataI      instruction word to write (registered, held)
//   softReset  one-cycle pulse to the core after a successful load
//   power      core run enable
//   busy       session in progress
//   done       load finished, core running
//   error      load aborted (bad length or bad checksum)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    output logic        writeI,
    output logic [31:0] TPC,
    output logic [31:0] dataI,
    output logic        softReset,
    output logic        power,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        IDLE,
        HDR0,
        HDR1,
        LOAD,
        WRITE,
        CHK,
        SRST,
        RUN,
        ERR
    } loaderState;

    loaderState state;
    loaderState nextState;

    logic [15:0] lenReg;
    logic [15:0] wordCnt;
    logic [15:0] wordCntNext;
    logic [1:0]  byteCnt;
    logic [7:0]  checksum;
    // Only the three earlier bytes of a word need holding; the fourth byte
    // goes straight from byteIn into dataI.
    logic [23:0] wordReg;
    logic [15:0] lenFull;
    logic        lenBad;
    logic        xfer;
    logic        sessionStart;

    assign xfer         = byteValid & byteReady;
    assign wordCntNext  = wordCnt + 16'd1;
    assign lenFull      = {lenReg[15:8], byteIn};
    assign lenBad       = (lenFull == 16'd0) || ({16'd0, lenFull} > MAX_WORDS);
    assign sessionStart = start && ((state == IDLE) || (state == RUN) || (state == ERR));

    // State register. Reset drops straight back to IDLE, so every status
    // output (all decoded from state) goes low within the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and state-decoded outputs. A start arriving while a session
    // is busy has no effect because only IDLE, RUN and ERR look at it.
    always_comb begin
        nextState = state;
        byteReady = 1'b0;
        writeI    = 1'b0;
        softReset = 1'b0;
        power     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (start) nextState = HDR0;
            end
            HDR0: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (xfer) nextState = HDR1;
            end
            HDR1: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (xfer) nextState = lenBad ? ERR : LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (xfer && (byteCnt == 2'd3)) nextState = WRITE;
            end
            WRITE: begin
                // The stream is stalled for this one cycle while the word
                // is written.
                busy      = 1'b1;
                writeI    = 1'b1;
                nextState = (wordCntNext == lenReg) ? CHK : LOAD;
            end
            CHK: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (xfer) nextState = (byteIn == checksum) ? SRST : ERR;
            end
            SRST: begin
                busy      = 1'b1;
                softReset = 1'b1;
                nextState = RUN;
            end
            RUN: begin
                power = 1'b1;
                done  = 1'b1;
                if (start) nextState = HDR0;
            end
            ERR: begin
                error = 1'b1;
                if (start) nextState = HDR0;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath: length capture, word assembly, checksum and the registered
    // write address/data. TPC and dataI are loaded when the fourth byte of a
    // word arrives, so they are already valid in the WRITE cycle and then
    // hold until the next word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lenReg   <= 16'd0;
            wordCnt  <= 16'd0;
            byteCnt  <= 2'd0;
            checksum <= 8'd0;
            wordReg  <= 24'd0;
            TPC      <= 32'd0;
            dataI    <= 32'd0;
        end else begin
            if (sessionStart) begin
                lenReg   <= 16'd0;
                wordCnt  <= 16'd0;
                byteCnt  <= 2'd0;
                checksum <= 8'd0;
            end
            case (state)
                HDR0: begin
                    if (xfer) lenReg[15:8] <= byteIn;
                end
                HDR1: begin
                    if (xfer) lenReg[7:0] <= byteIn;
                end
                LOAD: begin
                    if (xfer) begin
                        wordReg  <= {wordReg[15:0], byteIn};
                        checksum <= checksum ^ byteIn;
                        byteCnt  <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            dataI <= {wordReg, byteIn};
                            TPC   <= BASE_ADDR + {14'd0, wordCnt, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    wordCnt <= wordCntNext;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Frames are built as byte queues. A
// frame-level model derives the expected writes and outcome (run or error)
// directly from the frame contents. A negedge monitor checks every write
// strobe against the expected-write queue and checks status invariants on
// every cycle.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int unsigned MAX_WORDS = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    typedef logic [7:0] byteQ[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } writeRec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic        writeI;
    logic [31:0] TPC;
    logic [31:0] dataI;
    logic        softReset;
    logic        power;
    logic        busy;
    logic        done;
    logic        error;

    int      passCount  = 0;
    int      checkCount = 0;
    int      writeCount = 0;
    int      srstCount  = 0;
    bit      monEn      = 1'b0;
    writeRec expWrites[$];
    writeRec monRec;

    imem_loader #(
        .MAX_WORDS(MAX_WORDS),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .byteIn   (byteIn),
        .byteValid(byteValid),
        .byteReady(byteReady),
        .writeI   (writeI),
        .TPC      (TPC),
        .dataI    (dataI),
        .softReset(softReset),
        .power    (power),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends on its own.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 'h%0h, required 'h%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] modelXor(input byteQ f);
        int         n = {f[0], f[1]};
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x ^= f[2 + i];
        return x;
    endfunction

    function automatic logic [31:0] modelWord(input byteQ f, input int i);
        return {f[2 + 4 * i], f[3 + 4 * i], f[4 + 4 * i], f[5 + 4 * i]};
    endfunction

    task automatic buildFrame(input int n, input bit corrupt, output byteQ f);
        logic [31:0] w;
        logic [15:0] len;
        f = {};
        len = 16'(n);
        f.push_back(len[15:8]);
        f.push_back(len[7:0]);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            f.push_back(w[31:24]);
            f.push_back(w[23:16]);
            f.push_back(w[15:8]);
            f.push_back(w[7:0]);
        end
        f.push_back(modelXor(f) ^ (corrupt ? 8'($urandom_range(255, 1)) : 8'h00));
    endtask

    // Every cycle: at most one of busy/done/error, power exactly when done.
    // Each write strobe must match the next expected write and stall the stream.
    always @(negedge clk) begin
        if (monEn && !reset) begin
            checkOutput("status_exclusive", 32'($countones({busy, done, error}) <= 1), 32'd1);
            checkOutput("power_vs_done", 32'(power), 32'(done));
            if (writeI) begin
                writeCount++;
                checkOutput("write_stalls_stream", 32'(byteReady), 32'd0);
                checkOutput("write_expected", 32'(expWrites.size() != 0), 32'd1);
                if (expWrites.size() != 0) begin
                    monRec = expWrites.pop_front();
                    checkOutput("write_TPC", TPC, monRec.addr);
                    checkOutput("write_dataI", dataI, monRec.data);
                end
            end
            if (softReset) srstCount++;
        end
    end

    // Offer one byte after an optional idle gap. During the gap the byte
    // lines carry junk and start is toggled randomly; the session is busy
    // then, so start must be ignored.
    task automatic sendByte(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        repeat (gap) begin
            byteValid = 1'b0;
            byteIn    = 8'($urandom);
            start     = 1'($urandom);
            @(negedge clk);
        end
        start     = 1'b0;
        byteValid = 1'b1;
        byteIn    = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (byteReady) ok = 1'b1;
            @(negedge clk);
        end
        byteValid = 1'b0;
        byteIn    = 8'($urandom);
        checkOutput("byte_accepted", 32'(ok), 32'd1);
    endtask

    // Run one complete session for a frame and check the outcome.
    task automatic applyStimulus(input byteQ frame, input int maxGap);
        int      n;
        int      nSend;
        bit      hdrOk;
        bit      chkOk;
        bit      ok;
        writeRec r;
        expWrites.delete();
        writeCount = 0;
        srstCount  = 0;
        n     = {frame[0], frame[1]};
        hdrOk = (n != 0) && (n <= int'(MAX_WORDS));
        chkOk = hdrOk && (frame[2 + 4 * n] == modelXor(frame));
        if (hdrOk) begin
            for (int i = 0; i < n; i++) begin
                r.addr = BASE_ADDR + 32'(4 * i);
                r.data = modelWord(frame, i);
                expWrites.push_back(r);
            end
        end

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_power", 32'(power), 32'd0);
        checkOutput("start_error", 32'(error), 32'd0);
        checkOutput("start_done", 32'(done), 32'd0);

        nSend = hdrOk ? (4 * n + 3) : 2;
        for (int i = 0; i < nSend; i++) begin
            sendByte(frame[i], $urandom_range(maxGap, 0), ok);
            if (hdrOk && (i >= 2) && (i < 2 + 4 * n) && (((i - 2) % 4) == 3))
                checkOutput("writeI_latency", 32'(writeI), 32'd1);
        end

        if (!hdrOk) begin
            checkOutput("len_error", 32'(error), 32'd1);
            checkOutput("len_busy", 32'(busy), 32'd0);
        end else if (chkOk) begin
            checkOutput("softReset_latency", 32'(softReset), 32'd1);
            checkOutput("srst_power", 32'(power), 32'd0);
            @(negedge clk);
            checkOutput("run_power", 32'(power), 32'd1);
            checkOutput("run_done", 32'(done), 32'd1);
            checkOutput("run_softReset", 32'(softReset), 32'd0);
        end else begin
            checkOutput("chk_error", 32'(error), 32'd1);
            checkOutput("chk_power", 32'(power), 32'd0);
            checkOutput("chk_softReset", 32'(softReset), 32'd0);
        end

        repeat (3) @(negedge clk);
        checkOutput("write_count", 32'(writeCount), hdrOk ? 32'(n) : 32'd0);
        checkOutput("softReset_count", 32'(srstCount), 32'(chkOk));
        checkOutput("writes_left", 32'(expWrites.size()), 32'd0);
        checkOutput("final_done", 32'(done), 32'(chkOk));
        checkOutput("final_error", 32'(error), 32'(!chkOk));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_byteReady"}, 32'(byteReady), 32'd0);
        checkOutput({tag, "_writeI"}, 32'(writeI), 32'd0);
        checkOutput({tag, "_TPC"}, TPC, 32'd0);
        checkOutput({tag, "_dataI"}, dataI, 32'd0);
        checkOutput({tag, "_softReset"}, 32'(softReset), 32'd0);
        checkOutput({tag, "_power"}, 32'(power), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        byteQ    f1;
        byteQ    f1Bad;
        byteQ    f3;
        byteQ    fZero;
        byteQ    fBig;
        byteQ    fr;
        writeRec r;
        bit      ok;

        f1    = '{8'h00, 8'h01, 8'h20, 8'h01, 8'h00, 8'h05, 8'h24};
        f1Bad = '{8'h00, 8'h01, 8'h20, 8'h01, 8'h00, 8'h05, 8'h25};
        f3    = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                  8'h33, 8'h33, 8'h33, 8'h33, 8'h00};
        fZero = '{8'h00, 8'h00};
        fBig  = '{8'h01, 8'h01};

        reset     = 1'b1;
        start     = 1'b0;
        byteValid = 1'b0;
        byteIn    = 8'h00;
        repeat (2) @(negedge clk);
        checkAllZero("in_reset");
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("idle");
        monEn = 1'b1;

        $display("[TB] model pin checks");
        checkOutput("model_xor_f1", 32'(modelXor(f1)), 32'h24);
        checkOutput("model_word_f1", modelWord(f1, 0), 32'h2001_0005);
        checkOutput("model_xor_f3", 32'(modelXor(f3)), 32'h00);
        checkOutput("model_word_f3_2", modelWord(f3, 2), 32'h3333_3333);

        $display("[TB] one-word frame");
        applyStimulus(f1, 0);
        checkOutput("t1_TPC_held", TPC, 32'h0000_0000);
        checkOutput("t1_dataI_held", dataI, 32'h2001_0005);
        checkOutput("t1_power", 32'(power), 32'd1);

        $display("[TB] three-word frame");
        applyStimulus(f3, 0);
        checkOutput("t3_TPC_held", TPC, 32'h0000_0008);
        checkOutput("t3_dataI_held", dataI, 32'h3333_3333);

        $display("[TB] bad checksum then recovery");
        applyStimulus(f1Bad, 0);
        checkOutput("bad_chk_error", 32'(error), 32'd1);
        applyStimulus(f1, 1);

        $display("[TB] bad lengths");
        applyStimulus(fZero, 0);
        applyStimulus(fBig, 0);

        $display("[TB] three-word frame with gaps");
        applyStimulus(f3, 5);

        $display("[TB] reset in the middle of word 2");
        expWrites.delete();
        r.addr = BASE_ADDR;
        r.data = 32'h1111_1111;
        expWrites.push_back(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) sendByte(f3[i], 0, ok);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_byteReady", 32'(byteReady), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_TPC", TPC, 32'd0);
        checkOutput("midreset_dataI", dataI, 32'd0);
        checkOutput("midreset_power", 32'(power), 32'd0);
        checkOutput("midreset_writes", 32'(expWrites.size()), 32'd0);
        expWrites.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(f3, 2);

        $display("[TB] maximum length frame");
        buildFrame(int'(MAX_WORDS), 1'b0, fr);
        applyStimulus(fr, 0);
        checkOutput("max_TPC", TPC, BASE_ADDR + 32'(4 * (MAX_WORDS - 1)));

        $display("[TB] random frames");
        for (int t = 0; t < 10; t++) begin
            buildFrame($urandom_range(8, 1), ($urandom_range(3, 0) == 0), fr);
            applyStimulus(fr, $urandom_range(5, 0));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
